// File: rtl/draw_sequencer_if.sv
// Sequencer <-> draw-engine/VGA bundle: frame request, per-engine start/done and pixel buses,
// shared VGA write port and sticky status flags.
interface draw_sequencer_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int C_W = 3
);
    logic               frame_start;
    logic [2:0]         phase_en;
    logic [2:0]         start;
    logic [2:0]         done;
    logic [2:0]         plot_in;
    logic [3*X_W-1:0]   x_in;
    logic [3*Y_W-1:0]   y_in;
    logic [3*C_W-1:0]   colour_in;
    logic               plot;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [C_W-1:0]     colour;
    logic               busy;
    logic               frame_done;
    logic [2:0]         timeout_err;
    logic               overrun;
    logic               clear_err;

    modport master (
        input  frame_start, phase_en, done, plot_in, x_in, y_in, colour_in, clear_err,
        output start, plot, x, y, colour, busy, frame_done, timeout_err, overrun
    );

    modport slave (
        output frame_start, phase_en, done, plot_in, x_in, y_in, colour_in, clear_err,
        input  start, plot, x, y, colour, busy, frame_done, timeout_err, overrun
    );
endinterface

// File: rtl/draw_sequencer.sv
// Runs erase/pipes/bird engines in order per frame and muxes the active engine onto the VGA port.
// start one cycle after accept/phase exit, pixel mux 1 cycle; frame_start while busy is dropped and flagged.
module draw_sequencer #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int C_W     = 3,
    parameter int TIMEOUT = 20000
) (
    input  logic             clk,
    input  logic             resetn,
    draw_sequencer_if.master bus
);
    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, PH0, PH1, PH2} state_t;

    state_t          state;
    state_t          nxt_state;
    logic [2:0]      en_q;
    logic [2:0]      nxt_mask;
    logic [2:0]      nxt_start;
    logic [2:0]      tmo_set;
    logic [WD_W-1:0] wd;
    logic            in_ph;
    logic            first_cycle;
    logic            sel_done;
    logic            sel_plot;
    logic            done_ok;
    logic            wd_hit;
    logic            tmo_flag;
    logic            go;
    logic [X_W-1:0]  sel_x;
    logic [Y_W-1:0]  sel_y;
    logic [C_W-1:0]  sel_c;

    always_comb begin
        in_ph       = (state != IDLE);
        // start is high only in the first cycle of a phase, so it doubles as the entry marker
        first_cycle = |bus.start;
        sel_done    = 1'b0;
        sel_plot    = 1'b0;
        sel_x       = bus.x_in[X_W-1:0];
        sel_y       = bus.y_in[Y_W-1:0];
        sel_c       = bus.colour_in[C_W-1:0];
        case (state)
            PH0: begin
                sel_done = bus.done[0];
                sel_plot = bus.plot_in[0];
            end
            PH1: begin
                sel_done = bus.done[1];
                sel_plot = bus.plot_in[1];
                sel_x    = bus.x_in[2*X_W-1:X_W];
                sel_y    = bus.y_in[2*Y_W-1:Y_W];
                sel_c    = bus.colour_in[2*C_W-1:C_W];
            end
            PH2: begin
                sel_done = bus.done[2];
                sel_plot = bus.plot_in[2];
                sel_x    = bus.x_in[3*X_W-1:2*X_W];
                sel_y    = bus.y_in[3*Y_W-1:2*Y_W];
                sel_c    = bus.colour_in[3*C_W-1:2*C_W];
            end
            default: ;
        endcase

        done_ok  = in_ph && !first_cycle && sel_done;
        wd_hit   = in_ph && (wd == WD_LAST);
        tmo_flag = wd_hit && !done_ok;

        go       = 1'b0;
        nxt_mask = 3'b000;
        tmo_set  = 3'b000;
        case (state)
            IDLE: begin
                go       = bus.frame_start;
                nxt_mask = bus.phase_en;
            end
            PH0: begin
                go       = done_ok || wd_hit;
                nxt_mask = en_q & 3'b110;
                tmo_set  = {2'b00, tmo_flag};
            end
            PH1: begin
                go       = done_ok || wd_hit;
                nxt_mask = en_q & 3'b100;
                tmo_set  = {1'b0, tmo_flag, 1'b0};
            end
            default: begin
                go       = done_ok || wd_hit;
                nxt_mask = 3'b000;
                tmo_set  = {tmo_flag, 2'b00};
            end
        endcase

        // disabled phases are skipped in zero cycles by jumping to the lowest remaining one
        if (nxt_mask[0]) begin
            nxt_state = PH0;
            nxt_start = 3'b001;
        end else if (nxt_mask[1]) begin
            nxt_state = PH1;
            nxt_start = 3'b010;
        end else if (nxt_mask[2]) begin
            nxt_state = PH2;
            nxt_start = 3'b100;
        end else begin
            nxt_state = IDLE;
            nxt_start = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            en_q            <= 3'b000;
            wd              <= '0;
            bus.start       <= 3'b000;
            bus.busy        <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.plot        <= 1'b0;
            bus.x           <= '0;
            bus.y           <= '0;
            bus.colour      <= '0;
            bus.timeout_err <= 3'b000;
            bus.overrun     <= 1'b0;
        end else begin
            bus.start      <= 3'b000;
            bus.frame_done <= 1'b0;
            if (go) begin
                state          <= nxt_state;
                wd             <= '0;
                bus.start      <= nxt_start;
                bus.busy       <= (nxt_state != IDLE);
                bus.frame_done <= (nxt_state == IDLE);
                if (state == IDLE) begin
                    en_q <= bus.phase_en;
                end
            end else if (in_ph) begin
                wd <= wd + WD_W'(1);
            end

            if (in_ph) begin
                bus.plot   <= sel_plot;
                bus.x      <= sel_x;
                bus.y      <= sel_y;
                bus.colour <= sel_c;
            end else begin
                bus.plot <= 1'b0;
            end

            // a set event in the same cycle as clear_err must survive the clear
            bus.timeout_err <= (bus.clear_err ? 3'b000 : bus.timeout_err) | tmo_set;
            bus.overrun     <= (bus.clear_err ? 1'b0 : bus.overrun) | (bus.frame_start && in_ph);
        end
    end
endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: phase-level reference model compared every cycle, plus literal timing checks.
module tb_draw_sequencer;
    localparam int TO = 16;

    logic clk;
    logic resetn;
    int   total = 0;
    int   bad   = 0;
    bit   cmp_on = 0;
    int   dly [3];
    int   cnt [3];

    draw_sequencer_if #(.X_W(8), .Y_W(7), .C_W(3)) bus ();

    draw_sequencer #(.X_W(8), .Y_W(7), .C_W(3), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_fd(input int lim);
        int n = 0;
        while (!bus.frame_done && n < lim) begin
            step();
            n++;
        end
        chk("frame_done_wait", 32'(bus.frame_done), 1);
    endtask

    // reference model: phase number, cycles spent in the phase, captured enables
    int         m_ph = -1;
    int         m_age = 0;
    logic [2:0] m_en = 3'b000;
    logic [2:0] e_start = 3'b000, e_terr = 3'b000;
    logic       e_busy = 1'b0, e_fd = 1'b0, e_ov = 1'b0, e_plot = 1'b0;
    logic [7:0] e_x = 8'd0;
    logic [6:0] e_y = 7'd0;
    logic [2:0] e_c = 3'd0;

    function automatic int first_en(input logic [2:0] m, input int from);
        for (int k = from; k < 3; k++) if (m[k]) return k;
        return -1;
    endfunction

    initial forever begin : model
        logic [2:0] tset;
        logic       ov_set;
        bit         leave;
        bit         enter;
        int         nxt;
        @(posedge clk);
        if (!resetn) begin
            m_ph = -1; m_age = 0; m_en = 3'b000;
            e_start = 3'b000; e_terr = 3'b000; e_busy = 0; e_fd = 0; e_ov = 0;
            e_plot = 0; e_x = 0; e_y = 0; e_c = 0;
        end else begin
            tset = 3'b000;
            ov_set = bus.frame_start && (m_ph >= 0);
            e_start = 3'b000;
            e_fd = 0;
            leave = 0;
            enter = 0;
            nxt = -1;
            if (m_ph >= 0) begin
                e_plot = bus.plot_in[m_ph];
                e_x = bus.x_in[m_ph*8 +: 8];
                e_y = bus.y_in[m_ph*7 +: 7];
                e_c = bus.colour_in[m_ph*3 +: 3];
                if (m_age > 0 && bus.done[m_ph]) leave = 1;
                else if (m_age == TO - 1) begin
                    leave = 1;
                    tset[m_ph] = 1'b1;
                end
                m_age++;
                if (leave) begin
                    nxt = first_en(m_en, m_ph + 1);
                    enter = 1;
                end
            end else begin
                e_plot = 0;
                if (bus.frame_start) begin
                    m_en = bus.phase_en;
                    nxt = first_en(bus.phase_en, 0);
                    enter = 1;
                end
            end
            if (enter) begin
                m_ph = nxt;
                m_age = 0;
                if (nxt >= 0) e_start[nxt] = 1'b1;
                else e_fd = 1;
            end
            e_busy = (m_ph >= 0);
            e_terr = (bus.clear_err ? 3'b000 : e_terr) | tset;
            e_ov = (bus.clear_err ? 1'b0 : e_ov) | ov_set;
        end
    end

    initial forever begin : compare
        @(negedge clk);
        if (resetn && cmp_on) begin
            chk("start", 32'(bus.start), 32'(e_start));
            chk("busy", 32'(bus.busy), 32'(e_busy));
            chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
            chk("timeout_err", 32'(bus.timeout_err), 32'(e_terr));
            chk("overrun", 32'(bus.overrun), 32'(e_ov));
            chk("plot", 32'(bus.plot), 32'(e_plot));
            chk("x", 32'(bus.x), 32'(e_x));
            chk("y", 32'(bus.y), 32'(e_y));
            chk("colour", 32'(bus.colour), 32'(e_c));
        end
    end

    // engines: raise done dly[i] cycles after their start pulse (0 = never)
    initial forever begin : engines
        logic [2:0] d;
        @(negedge clk);
        d = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (!resetn) cnt[i] = 0;
            else begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) d[i] = 1'b1;
                end
                if (bus.start[i] && dly[i] > 0) cnt[i] = dly[i];
            end
        end
        bus.done = d;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int ts0, ts1, ts2, tfd, nb, ns1, np;
        resetn = 1'b0;
        bus.frame_start = 0; bus.phase_en = 3'b000; bus.plot_in = 3'b000;
        bus.x_in = '0; bus.y_in = '0; bus.colour_in = '0; bus.clear_err = 0;
        bus.done = 3'b000;
        dly = '{5, 5, 5};
        cnt = '{0, 0, 0};
        repeat (3) step();
        chk("rst_start", 32'(bus.start), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_plot", 32'(bus.plot), 0);
        chk("rst_terr", 32'(bus.timeout_err), 0);
        cmp_on = 1;

        // all phases, frame_start on the first edge after reset release
        resetn = 1'b1; bus.frame_start = 1; bus.phase_en = 3'b111;
        step();
        bus.frame_start = 0; bus.phase_en = 3'b000;
        ts0 = -1; ts1 = -1; ts2 = -1; tfd = -1; nb = 0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.start[0] && ts0 < 0) ts0 = k;
            if (bus.start[1] && ts1 < 0) ts1 = k;
            if (bus.start[2] && ts2 < 0) ts2 = k;
            if (bus.frame_done && tfd < 0) tfd = k;
            if (bus.busy) nb++;
            step();
        end
        chk("s1_start0_cycle", ts0, 1);
        chk("s1_start1_cycle", ts1, 7);
        chk("s1_start2_cycle", ts2, 13);
        chk("s1_frame_done_cycle", tfd, 19);
        chk("s1_busy_cycles", nb, 18);

        // pipes disabled; engine 1 plotting must never reach the port
        bus.phase_en = 3'b101; bus.plot_in = 3'b010; bus.frame_start = 1;
        step();
        bus.frame_start = 0;
        ts2 = -1; tfd = -1; ns1 = 0; np = 0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.start[1]) ns1++;
            if (bus.start[2] && ts2 < 0) ts2 = k;
            if (bus.plot) np++;
            if (bus.frame_done && tfd < 0) tfd = k;
            step();
        end
        chk("s2_start1_count", ns1, 0);
        chk("s2_start2_cycle", ts2, 7);
        chk("s2_plot_count", np, 0);
        chk("s2_frame_done_cycle", tfd, 13);
        bus.plot_in = 3'b000;

        // pixel mux in PH1, engine 0 strobe ignored
        bus.phase_en = 3'b010; bus.frame_start = 1;
        step();
        bus.frame_start = 0;
        chk("s3_start", 32'(bus.start), 32'(3'b010));
        step(); step();
        bus.plot_in = 3'b011;
        bus.x_in = {8'd0, 8'd159, 8'd7};
        bus.y_in = {7'd0, 7'd119, 7'd3};
        bus.colour_in = {3'd0, 3'b010, 3'b111};
        step();
        chk("s3_plot", 32'(bus.plot), 1);
        chk("s3_x", 32'(bus.x), 159);
        chk("s3_y", 32'(bus.y), 119);
        chk("s3_colour", 32'(bus.colour), 2);
        bus.plot_in = 3'b001;
        step();
        chk("s3_plot_eng0", 32'(bus.plot), 0);
        bus.plot_in = 3'b000;
        wait_fd(30);
        step();
        chk("s3_idle_plot", 32'(bus.plot), 0);
        chk("s3_hold_x", 32'(bus.x), 159);

        // engine 0 never finishes; clear_err held across the set cycle
        dly = '{0, 3, 5};
        bus.phase_en = 3'b011; bus.frame_start = 1;
        step();
        bus.frame_start = 0; bus.clear_err = 1;
        repeat (15) step();
        chk("s4_terr_before", 32'(bus.timeout_err), 0);
        step();
        chk("s4_start1", 32'(bus.start), 32'(3'b010));
        chk("s4_terr_set", 32'(bus.timeout_err), 32'(3'b001));
        step();
        chk("s4_terr_clr", 32'(bus.timeout_err), 0);
        bus.clear_err = 0;
        wait_fd(20);

        // done on the last watchdog cycle wins
        dly = '{15, 5, 5};
        step();
        bus.phase_en = 3'b001; bus.frame_start = 1;
        step();
        bus.frame_start = 0;
        repeat (16) step();
        chk("s5_tie_terr", 32'(bus.timeout_err), 0);
        chk("s5_tie_fd", 32'(bus.frame_done), 1);

        // overrun in PH1, then reset mid-PH2
        dly = '{5, 5, 5};
        step();
        bus.phase_en = 3'b111; bus.frame_start = 1;
        step();
        bus.frame_start = 0;
        repeat (7) step();
        bus.frame_start = 1;
        step();
        bus.frame_start = 0;
        chk("s6_overrun", 32'(bus.overrun), 1);
        chk("s6_busy", 32'(bus.busy), 1);
        repeat (6) step();
        resetn = 1'b0;
        #1;
        chk("s6_async_busy", 32'(bus.busy), 0);
        step();
        chk("s6_rst_start", 32'(bus.start), 0);
        chk("s6_rst_overrun", 32'(bus.overrun), 0);
        chk("s6_rst_x", 32'(bus.x), 0);
        chk("s6_rst_y", 32'(bus.y), 0);
        chk("s6_rst_colour", 32'(bus.colour), 0);
        chk("s6_rst_fd", 32'(bus.frame_done), 0);
        resetn = 1'b1; bus.frame_start = 1;
        step();
        bus.frame_start = 0;
        chk("s6_restart_ph0", 32'(bus.start), 32'(3'b001));
        wait_fd(40);

        // empty frame, then a request in the frame_done cycle
        step();
        bus.phase_en = 3'b000; bus.frame_start = 1;
        step();
        chk("s7_empty_fd", 32'(bus.frame_done), 1);
        chk("s7_empty_busy", 32'(bus.busy), 0);
        bus.phase_en = 3'b100;
        step();
        bus.frame_start = 0;
        chk("s7_accept_start", 32'(bus.start), 32'(3'b100));
        chk("s7_accept_busy", 32'(bus.busy), 1);
        chk("s7_no_overrun", 32'(bus.overrun), 0);
        wait_fd(20);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 Parameter: X_W, 8, pixel x width (160-column screen).
REQ-002 Parameter: Y_W, 7, pixel y width (120-row screen).
REQ-003 Parameter: C_W, 3, colour width.
REQ-004 Parameter: TIMEOUT, 20000, maximum cycles per phase before abort.
REQ-005 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-006 Port: resetn  input  1  asynchronous, active-low reset.
REQ-007 Port: frame_start  input  1  one-cycle request to draw one frame.
REQ-008 Port: phase_en  input  3  per-phase enable: [0] erase, [1] pipes, [2] bird.
REQ-009 Port: start  output  3  one-hot, one-cycle start pulse to the phase-i draw engine.
REQ-010 Port: done  input  3  draw engine i finished.
REQ-011 Port: plot_in  input  3  per-engine pixel-write strobe.
REQ-012 Port: x_in / y_in / colour_in  input  3*X_W / 3*Y_W / 3*C_W  per-engine pixel buses, engine i in slice i.
REQ-013 Port: plot / x / y / colour  output  1 / X_W / Y_W / C_W  shared VGA write port.
REQ-014 Port: busy  output  1  high while any phase is active.
REQ-015 Port: frame_done  output  1  one-cycle pulse at frame completion.
REQ-016 Port: timeout_err  output  3  sticky per-phase timeout flags.
REQ-017 Port: overrun  output  1  sticky flag: frame_start arrived while busy.
REQ-018 Port: clear_err  input  1  synchronous clear of timeout_err and overrun.

Function
REQ-019 FSM states: IDLE, PH0 (erase), PH1 (pipes), PH2 (bird); phases always run in order 0, 1, 2.
REQ-020 phase_en is captured on the accepted frame_start; later changes do not affect the frame in progress.
REQ-021 IDLE + frame_start: next state is the lowest enabled phase; with no phase enabled, go to IDLE and pulse frame_done next cycle.
REQ-022 Entering PHi: start[i]=1 in the first cycle of PHi only; busy=1 in every PH state.
REQ-023 done[i] is honoured only in PHi and not in its first cycle; done of other engines is ignored.
REQ-024 PHi exit: advance to the next enabled phase (disabled phases take zero cycles), or to IDLE if none remain.
REQ-025 Last phase exit in cycle n: state=IDLE and frame_done=1 in cycle n+1; a frame_start in that cycle is accepted.
REQ-026 Watchdog: per-phase cycle counter, cleared on phase entry; at count TIMEOUT-1 without done, set timeout_err[i] and exit the phase as if done.
REQ-027 done and timeout in the same cycle: done wins; timeout_err is unchanged.
REQ-028 Pixel mux: in PHi, register plot_in[i], x_in, y_in and colour_in slice i to the outputs, 1-cycle latency; other engines' buses are ignored.
REQ-029 Outside PH states, plot=0 and x/y/colour hold their last values.
REQ-030 Pixel presented in the same cycle as the honoured done is still forwarded.
REQ-031 frame_start while busy: ignored; overrun set.
REQ-032 clear_err clears all sticky flags; a set event in the same cycle takes priority over the clear.

Reset
REQ-033 resetn low, at any time including mid-phase: state=IDLE, start=0, plot=0, x=0, y=0, colour=0, busy=0, frame_done=0, timeout_err=0, overrun=0, watchdog=0, captured enable=0.
REQ-034 First frame_start is accepted on the first clock edge after resetn deasserts.

Verification
REQ-035 phase_en=111, frame_start at t0; each engine raises done 5 cycles after its start -> start pulses 001, 010, 100 at t1, t7, t13; frame_done at t19; busy high t1..t18.
REQ-036 phase_en=101 -> PH1 is skipped, start[1] never pulses, start[2] pulses in the cycle after PH0 exit; engine-1 plot_in=1 throughout -> plot never reflects it.
REQ-037 In PH1, engine 1 drives plot_in=1, x=159, y=119, colour=3'b010 -> plot=1, x=159, y=119, colour=010 one cycle later; engine 0 driving plot_in=1 in the same cycle has no effect.
REQ-038 TIMEOUT=16; engine 0 never asserts done -> exits after 16 cycles, timeout_err=001, PH1 starts; clear_err -> 000.
REQ-039 frame_start during PH1 -> ignored, overrun=1; resetn pulsed low mid-PH2 -> all outputs 0, and the next frame_start begins at PH0.
REQ-040 phase_en=000 with frame_start at t0 -> frame_done at t1, busy never asserts.
